// File: rtl/mesi_snoop_responder_if.sv
// Snoop bus, flush handshake and local update port bundle for mesi_snoop_responder.
// slave = responder side, master = bus/controller side.
interface mesi_snoop_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WAYS   = 8
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ready;
  logic              resp_valid;
  logic              snoop_hit;
  logic              snoop_hitm;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_addr;
  logic              flush_ready;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [WAY_W-1:0]  upd_way;
  logic [1:0]        upd_state;
  logic              proto_err;

  modport slave (
    input  bus_valid, bus_op, bus_addr, flush_ready,
    input  upd_valid, upd_addr, upd_way, upd_state,
    output bus_ready, resp_valid, snoop_hit, snoop_hitm,
    output flush_valid, flush_addr, proto_err
  );

  modport master (
    output bus_valid, bus_op, bus_addr, flush_ready,
    output upd_valid, upd_addr, upd_way, upd_state,
    input  bus_ready, resp_valid, snoop_hit, snoop_hitm,
    input  flush_valid, flush_addr, proto_err
  );
endinterface

// File: rtl/mesi_snoop_responder.sv
// MESI snoop responder: tag/state lookup, HIT/HITM response, M-line flush, state commit.
// Optional SNOOP_ERR_CHECK_EN: BusUpgr hitting E/M sets a sticky proto_err.
module mesi_snoop_responder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 8,
  parameter int unsigned OFF_W  = 6
) (
  input logic                   clk,
  input logic                   rst,
  mesi_snoop_responder_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned LINE_W = ADDR_W - OFF_W;

  localparam logic [1:0] MesiM = 2'b00;
  localparam logic [1:0] MesiE = 2'b01;
  localparam logic [1:0] MesiS = 2'b10;
  localparam logic [1:0] MesiI = 2'b11;

  localparam logic [1:0] OpRd   = 2'b00;
  localparam logic [1:0] OpRdX  = 2'b01;
  localparam logic [1:0] OpUpgr = 2'b10;

  typedef enum logic [1:0] {StIdle, StLookup, StFlush, StResp} fsm_e;

  // Line array: tags are never reset, only the states are.
  logic [TAG_W-1:0] tag_q     [SETS][WAYS];
  logic [1:0]       line_st_q [SETS][WAYS];

  fsm_e              fsm_q, fsm_d;
  logic [1:0]        op_q, op_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [1:0]        nxt_st_q, nxt_st_d;
  logic              wr_en_q, wr_en_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              rsp_hitm_q, rsp_hitm_d;
  logic              bus_ready_q, bus_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              snoop_hit_q, snoop_hit_d;
  logic              snoop_hitm_q, snoop_hitm_d;
  logic              flush_valid_q, flush_valid_d;
  logic [ADDR_W-1:0] flush_addr_q, flush_addr_d;
  logic              proto_err_q, proto_err_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [WAY_W-1:0]  lk_way;
  logic [1:0]        lk_st;

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              tag_we;
  logic              st_we;
  logic [IDX_W-1:0]  st_idx;
  logic [WAY_W-1:0]  st_way;
  logic [1:0]        st_val;

  assign lk_idx  = line_q[IDX_W-1:0];
  assign lk_tag  = line_q[LINE_W-1:IDX_W];
  assign upd_idx = bus.upd_addr[OFF_W +: IDX_W];
  assign upd_tag = bus.upd_addr[ADDR_W-1 -: TAG_W];

  // Scan from the top way down so the lowest matching way is the one kept.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    lk_st  = MesiI;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (tag_q[lk_idx][w] == lk_tag && line_st_q[lk_idx][w] != MesiI) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_st  = line_st_q[lk_idx][w];
      end
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    op_d          = op_q;
    line_d        = line_q;
    way_d         = way_q;
    nxt_st_d      = nxt_st_q;
    wr_en_d       = wr_en_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_hitm_d    = rsp_hitm_q;
    resp_valid_d  = 1'b0;
    snoop_hit_d   = 1'b0;
    snoop_hitm_d  = 1'b0;
    flush_valid_d = flush_valid_q;
    flush_addr_d  = flush_addr_q;
    proto_err_d   = proto_err_q;
    tag_we        = 1'b0;
    st_we         = 1'b0;
    st_idx        = upd_idx;
    st_way        = bus.upd_way;
    st_val        = bus.upd_state;

    unique case (fsm_q)
      StIdle: begin
        if (bus.upd_valid) begin
          tag_we = 1'b1;
          st_we  = 1'b1;
        end
        if (bus.bus_valid) begin
          op_d   = bus.bus_op;
          line_d = bus.bus_addr[ADDR_W-1:OFF_W];
          fsm_d  = StLookup;
        end
      end

      StLookup: begin
        way_d      = lk_way;
        nxt_st_d   = lk_st;
        wr_en_d    = 1'b0;
        rsp_hit_d  = 1'b0;
        rsp_hitm_d = 1'b0;
        // Op 2'b11 is accepted but treated as a miss.
        if (lk_hit && op_q != 2'b11) begin
          wr_en_d    = 1'b1;
          rsp_hit_d  = (lk_st != MesiM);
          rsp_hitm_d = (lk_st == MesiM);
          nxt_st_d   = (op_q == OpRd) ? MesiS : MesiI;
`ifdef SNOOP_ERR_CHECK_EN
          if (op_q == OpUpgr && lk_st != MesiS) begin
            proto_err_d = 1'b1;
          end
`endif
        end
        if (lk_hit && lk_st == MesiM && (op_q == OpRd || op_q == OpRdX)) begin
          fsm_d         = StFlush;
          flush_valid_d = 1'b1;
          flush_addr_d  = {line_q, {OFF_W{1'b0}}};
        end else begin
          fsm_d        = StResp;
          resp_valid_d = 1'b1;
          snoop_hit_d  = rsp_hit_d;
          snoop_hitm_d = rsp_hitm_d;
        end
      end

      StFlush: begin
        if (bus.flush_ready) begin
          flush_valid_d = 1'b0;
          fsm_d         = StResp;
          resp_valid_d  = 1'b1;
          snoop_hit_d   = rsp_hit_q;
          snoop_hitm_d  = rsp_hitm_q;
        end
      end

      StResp: begin
        st_we  = wr_en_q;
        st_idx = lk_idx;
        st_way = way_q;
        st_val = nxt_st_q;
        fsm_d  = StIdle;
      end

      default: fsm_d = StIdle;
    endcase

    bus_ready_d = (fsm_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= StIdle;
      op_q          <= 2'b00;
      line_q        <= '0;
      way_q         <= '0;
      nxt_st_q      <= MesiI;
      wr_en_q       <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_hitm_q    <= 1'b0;
      bus_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      snoop_hit_q   <= 1'b0;
      snoop_hitm_q  <= 1'b0;
      flush_valid_q <= 1'b0;
      flush_addr_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      op_q          <= op_d;
      line_q        <= line_d;
      way_q         <= way_d;
      nxt_st_q      <= nxt_st_d;
      wr_en_q       <= wr_en_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_hitm_q    <= rsp_hitm_d;
      bus_ready_q   <= bus_ready_d;
      resp_valid_q  <= resp_valid_d;
      snoop_hit_q   <= snoop_hit_d;
      snoop_hitm_q  <= snoop_hitm_d;
      flush_valid_q <= flush_valid_d;
      flush_addr_q  <= flush_addr_d;
      proto_err_q   <= proto_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          line_st_q[s][w] <= MesiI;
        end
      end
    end else if (st_we) begin
      line_st_q[st_idx][st_way] <= st_val;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[upd_idx][bus.upd_way] <= upd_tag;
    end
  end

  assign bus.bus_ready   = bus_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.snoop_hit   = snoop_hit_q;
  assign bus.snoop_hitm  = snoop_hitm_q;
  assign bus.flush_valid = flush_valid_q;
  assign bus.flush_addr  = flush_addr_q;
  assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed self-checking bench for mesi_snoop_responder.
module tb_mesi_snoop_responder;
  localparam logic [1:0] OP_RD = 2'b00, OP_RDX = 2'b01, OP_UPGR = 2'b10, OP_NONE = 2'b11;
  localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10;
`ifdef SNOOP_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  mesi_snoop_responder_if #(.ADDR_W(32), .WAYS(8)) bif ();

  mesi_snoop_responder #(.ADDR_W(32), .SETS(16), .WAYS(8), .OFF_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic install(input logic [31:0] a, input logic [2:0] w, input logic [1:0] s);
    bif.upd_valid = 1'b1;
    bif.upd_addr  = a;
    bif.upd_way   = w;
    bif.upd_state = s;
    tick();
    bif.upd_valid = 1'b0;
  endtask

  // Returns one cycle after the accepting edge (LOOKUP cycle).
  task automatic snoop(input logic [1:0] op, input logic [31:0] a);
    bif.bus_valid = 1'b1;
    bif.bus_op    = op;
    bif.bus_addr  = a;
    tick();
    bif.bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bif.bus_ready !== 1'b1) begin errors++; $display("FAIL rst_bus_ready: got %b want 1", bif.bus_ready); end
    checks++; if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bif.resp_valid); end
    checks++; if (bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b want 0", bif.snoop_hit); end
    checks++; if (bif.snoop_hitm !== 1'b0) begin errors++; $display("FAIL rst_hitm: got %b want 0", bif.snoop_hitm); end
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid: got %b want 0", bif.flush_valid); end
    checks++; if (bif.flush_addr !== 32'h0) begin errors++; $display("FAIL rst_flush_addr: got %h want 0", bif.flush_addr); end
    checks++; if (bif.proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b want 0", bif.proto_err); end
  endtask

  task automatic test_hit_e();
    install(32'h0004_8D40, 3'd2, ST_E);
    snoop(OP_RD, 32'h0004_8D7C);
    checks++; if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL e_lookup_resp: got %b want 0", bif.resp_valid); end
    tick();
    checks++; if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL e_resp_valid: got %b want 1", bif.resp_valid); end
    checks++; if (bif.snoop_hit !== 1'b1) begin errors++; $display("FAIL e_hit: got %b want 1", bif.snoop_hit); end
    checks++; if (bif.snoop_hitm !== 1'b0) begin errors++; $display("FAIL e_hitm: got %b want 0", bif.snoop_hitm); end
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL e_flush: got %b want 0", bif.flush_valid); end
    checks++; if (bif.bus_ready !== 1'b0) begin errors++; $display("FAIL e_ready_busy: got %b want 0", bif.bus_ready); end
    tick();
    checks++; if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL e_resp_strobe: got %b want 0", bif.resp_valid); end
    checks++; if (bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL e_hit_clear: got %b want 0", bif.snoop_hit); end
    checks++; if (bif.bus_ready !== 1'b1) begin errors++; $display("FAIL e_ready_back: got %b want 1", bif.bus_ready); end
    snoop(OP_RD, 32'h0004_8D40); tick();
    checks++; if (bif.snoop_hit !== 1'b1) begin errors++; $display("FAIL s_rd_hit: got %b want 1", bif.snoop_hit); end
    tick();
    snoop(OP_RDX, 32'h0004_8D40); tick();
    checks++; if (bif.snoop_hit !== 1'b1) begin errors++; $display("FAIL s_rdx_hit: got %b want 1", bif.snoop_hit); end
    tick();
    snoop(OP_RD, 32'h0004_8D40); tick();
    checks++; if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL i_resp: got %b want 1", bif.resp_valid); end
    checks++; if (bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL i_after_rdx: got %b want 0", bif.snoop_hit); end
    tick();
  endtask

  task automatic test_flush_m();
    install(32'h0004_8D40, 3'd2, ST_M);
    bif.flush_ready = 1'b0;
    snoop(OP_RDX, 32'h0004_8D44);
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL m_flush_early: got %b want 0", bif.flush_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bif.flush_valid !== 1'b1) begin errors++; $display("FAIL m_flush_hold%0d: got %b want 1", i, bif.flush_valid); end
      checks++; if (bif.flush_addr !== 32'h0004_8D40) begin errors++; $display("FAIL m_flush_addr%0d: got %h want 00048d40", i, bif.flush_addr); end
      checks++; if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL m_resp_early%0d: got %b want 0", i, bif.resp_valid); end
    end
    tick();
    bif.flush_ready = 1'b1;
    checks++; if (bif.flush_valid !== 1'b1) begin errors++; $display("FAIL m_flush_hs: got %b want 1", bif.flush_valid); end
    tick();
    bif.flush_ready = 1'b0;
    checks++; if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL m_resp: got %b want 1", bif.resp_valid); end
    checks++; if (bif.snoop_hitm !== 1'b1) begin errors++; $display("FAIL m_hitm: got %b want 1", bif.snoop_hitm); end
    checks++; if (bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL m_hit: got %b want 0", bif.snoop_hit); end
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL m_flush_drop: got %b want 0", bif.flush_valid); end
    tick();
    snoop(OP_RD, 32'h0004_8D40); tick();
    checks++; if (bif.snoop_hit !== 1'b0 || bif.snoop_hitm !== 1'b0) begin errors++; $display("FAIL m_rdx_to_i: got %b%b want 00", bif.snoop_hit, bif.snoop_hitm); end
    tick();
    // BusRd on M with an immediate flush handshake leaves the line in S.
    install(32'h0004_8D40, 3'd5, ST_M);
    bif.flush_ready = 1'b1;
    snoop(OP_RD, 32'h0004_8D40); tick();
    checks++; if (bif.flush_valid !== 1'b1 || bif.resp_valid !== 1'b0) begin errors++; $display("FAIL m_rd_flush: got fv=%b rv=%b want fv=1 rv=0", bif.flush_valid, bif.resp_valid); end
    tick();
    bif.flush_ready = 1'b0;
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hitm !== 1'b1) begin errors++; $display("FAIL m_rd_resp: got rv=%b hitm=%b want 1 1", bif.resp_valid, bif.snoop_hitm); end
    tick();
    snoop(OP_RD, 32'h0004_8D40); tick();
    checks++; if (bif.snoop_hit !== 1'b1 || bif.snoop_hitm !== 1'b0) begin errors++; $display("FAIL m_rd_to_s: got %b%b want 10", bif.snoop_hit, bif.snoop_hitm); end
    tick();
  endtask

  task automatic test_miss();
    snoop(OP_RD, 32'h1234_5000);
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL miss_flush_c1: got %b want 0", bif.flush_valid); end
    tick();
    checks++; if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL miss_resp: got %b want 1", bif.resp_valid); end
    checks++; if (bif.snoop_hit !== 1'b0 || bif.snoop_hitm !== 1'b0) begin errors++; $display("FAIL miss_hits: got %b%b want 00", bif.snoop_hit, bif.snoop_hitm); end
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL miss_flush_c2: got %b want 0", bif.flush_valid); end
    tick();
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL miss_flush_c3: got %b want 0", bif.flush_valid); end
  endtask

  task automatic test_op_ignored();
    install(32'h0000_2080, 3'd0, ST_E);
    snoop(OP_NONE, 32'h0000_2080); tick();
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL op11_resp: got rv=%b hit=%b want 1 0", bif.resp_valid, bif.snoop_hit); end
    tick();
    snoop(OP_RD, 32'h0000_2080); tick();
    checks++; if (bif.snoop_hit !== 1'b1) begin errors++; $display("FAIL op11_unchanged: got %b want 1", bif.snoop_hit); end
    tick();
  endtask

  task automatic test_proto_err();
    install(32'h0001_0100, 3'd1, ST_E);
    snoop(OP_UPGR, 32'h0001_0100); tick();
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hit !== 1'b1) begin errors++; $display("FAIL upgr_e_resp: got rv=%b hit=%b want 1 1", bif.resp_valid, bif.snoop_hit); end
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL upgr_e_flush: got %b want 0", bif.flush_valid); end
    checks++; if (bif.proto_err !== EXP_ERR) begin errors++; $display("FAIL upgr_e_err: got %b want %b", bif.proto_err, EXP_ERR); end
    tick(); tick();
    checks++; if (bif.proto_err !== EXP_ERR) begin errors++; $display("FAIL upgr_err_sticky: got %b want %b", bif.proto_err, EXP_ERR); end
    snoop(OP_RD, 32'h0001_0100); tick();
    checks++; if (bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL upgr_e_to_i: got %b want 0", bif.snoop_hit); end
    tick();
    install(32'h0001_0140, 3'd0, ST_M);
    snoop(OP_UPGR, 32'h0001_0140); tick();
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hitm !== 1'b1 || bif.flush_valid !== 1'b0) begin errors++; $display("FAIL upgr_m: got rv=%b hitm=%b fv=%b want 1 1 0", bif.resp_valid, bif.snoop_hitm, bif.flush_valid); end
    tick();
    snoop(OP_RD, 32'h0001_0140); tick();
    checks++; if (bif.snoop_hitm !== 1'b0 || bif.flush_valid !== 1'b0) begin errors++; $display("FAIL upgr_m_to_i: got hitm=%b fv=%b want 0 0", bif.snoop_hitm, bif.flush_valid); end
    tick();
  endtask

  task automatic test_reset_in_flush();
    install(32'h0003_0300, 3'd4, ST_M);
    bif.flush_ready = 1'b0;
    snoop(OP_RD, 32'h0003_0300); tick();
    checks++; if (bif.flush_valid !== 1'b1) begin errors++; $display("FAIL rf_flush_pre: got %b want 1", bif.flush_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bif.flush_valid !== 1'b0) begin errors++; $display("FAIL rf_flush_async: got %b want 0", bif.flush_valid); end
    checks++; if (bif.proto_err !== 1'b0) begin errors++; $display("FAIL rf_err_clear: got %b want 0", bif.proto_err); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bif.bus_ready !== 1'b1 || bif.flush_valid !== 1'b0) begin errors++; $display("FAIL rf_after: got rdy=%b fv=%b want 1 0", bif.bus_ready, bif.flush_valid); end
    snoop(OP_RD, 32'h0003_0300); tick();
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hit !== 1'b0 || bif.snoop_hitm !== 1'b0) begin errors++; $display("FAIL rf_resnoop: got rv=%b hit=%b hitm=%b want 1 0 0", bif.resp_valid, bif.snoop_hit, bif.snoop_hitm); end
    tick();
  endtask

  task automatic test_upd_collision();
    bif.upd_valid = 1'b1; bif.upd_addr = 32'h0002_0200; bif.upd_way = 3'd3; bif.upd_state = ST_S;
    bif.bus_valid = 1'b1; bif.bus_op = OP_RD; bif.bus_addr = 32'h0002_0200;
    tick();
    bif.upd_valid = 1'b0; bif.bus_valid = 1'b0;
    tick();
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hit !== 1'b1) begin errors++; $display("FAIL col_hit: got rv=%b hit=%b want 1 1", bif.resp_valid, bif.snoop_hit); end
    tick();
    snoop(OP_UPGR, 32'h0002_0200); tick();
    checks++; if (bif.snoop_hit !== 1'b1 || bif.proto_err !== 1'b0) begin errors++; $display("FAIL col_s_upgr: got hit=%b err=%b want 1 0", bif.snoop_hit, bif.proto_err); end
    tick();
    snoop(OP_RD, 32'h0002_0240);
    checks++; if (bif.bus_ready !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b want 0", bif.bus_ready); end
    bif.upd_valid = 1'b1; bif.upd_addr = 32'h0002_0240; bif.upd_way = 3'd0; bif.upd_state = ST_E;
    tick();
    bif.upd_valid = 1'b0;
    tick();
    snoop(OP_RD, 32'h0002_0240); tick();
    checks++; if (bif.resp_valid !== 1'b1 || bif.snoop_hit !== 1'b0) begin errors++; $display("FAIL drop_upd: got rv=%b hit=%b want 1 0", bif.resp_valid, bif.snoop_hit); end
    tick();
  endtask

  task automatic test_back_to_back();
    bif.bus_valid = 1'b1; bif.bus_op = OP_RD; bif.bus_addr = 32'h0004_0000;
    tick();
    checks++; if (bif.bus_ready !== 1'b0) begin errors++; $display("FAIL b2b_c1_ready: got %b want 0", bif.bus_ready); end
    tick();
    checks++; if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_c2_resp: got %b want 1", bif.resp_valid); end
    tick();
    checks++; if (bif.resp_valid !== 1'b0 || bif.bus_ready !== 1'b1) begin errors++; $display("FAIL b2b_c3: got rv=%b rdy=%b want 0 1", bif.resp_valid, bif.bus_ready); end
    tick();
    bif.bus_valid = 1'b0;
    checks++; if (bif.resp_valid !== 1'b0 || bif.bus_ready !== 1'b0) begin errors++; $display("FAIL b2b_c4: got rv=%b rdy=%b want 0 0", bif.resp_valid, bif.bus_ready); end
    tick();
    checks++; if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_c5_resp: got %b want 1", bif.resp_valid); end
    tick();
  endtask

  initial begin
    bif.bus_valid = 1'b0; bif.bus_op = 2'b00; bif.bus_addr = '0; bif.flush_ready = 1'b0;
    bif.upd_valid = 1'b0; bif.upd_addr = '0; bif.upd_way = '0; bif.upd_state = 2'b11;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_reset();
    test_hit_e();
    test_flush_m();
    test_miss();
    test_op_ignored();
    test_proto_err();
    test_reset_in_flush();
    test_upd_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
